// File: rtl/lowres_framebuffer.sv
// lowres_framebuffer: 160x120 frame of 6-bit palette indices, scaled 4x4 onto
// a 640x480 VGA raster. Feeds vga.color from vga.row/vga.col, with lookahead
// prefetch so color is valid in every clock of any pixel period >= 2 clocks.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   row, col           : current raster position from the vga timing block
//   color              : palette index out, bits [7:6] always 0
//   wr_valid/wr_ready  : host write handshake; wr_addr = y*FB_W + x, wr_data
//                        out-of-range addresses are acknowledged and dropped
//   clr_start          : one-cycle pulse, fills the whole frame with clr_color
//   clr_busy           : high while the fill runs (FB_W*FB_H clocks)
//
// Optional macro FB_RESET_CLEAR_EN: reset starts a fill with color 0 instead
// of idling, so the frame is all-black once clr_busy drops.
module lowres_framebuffer #(
  parameter int unsigned FB_W       = 160,
  parameter int unsigned FB_H       = 120,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        row,
  input  logic [9:0]        col,
  output logic [7:0]        color,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [5:0]        wr_data,
  input  logic              clr_start,
  input  logic [5:0]        clr_color,
  output logic              clr_busy
);

  localparam int unsigned DEPTH  = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd524;
  localparam logic [9:0] H_VIS  = 10'(FB_W << SCALE_LOG2);
  localparam logic [9:0] V_VIS  = 10'(FB_H << SCALE_LOG2);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Frame storage; contents are never reset
  logic [5:0] mem [DEPTH];

  logic [9:0]        col_q, col_d;
  logic [5:0]        cur_q, cur_d;
  logic [5:0]        next_q, next_d;
  logic [5:0]        rd_data_q;
  logic              pf_pend_q, pf_pend_d;
  logic              pf_off_q, pf_off_d;
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [5:0]        clr_color_q, clr_color_d;

  logic [9:0]        nxt_col, nxt_row;
  logic              pf_on;
  logic [ADDR_W-1:0] sy, sx, row_base, rd_addr;
  logic              chg;
  logic [5:0]        px;
  logic              clr_we, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [5:0]        mem_wdata;

  // Raster position one pixel ahead of the current one
  always_comb begin
    nxt_col = (col == H_LAST) ? 10'd0 : col + 10'd1;
    nxt_row = row;
    if (col == H_LAST) begin
      nxt_row = (row == V_LAST) ? 10'd0 : row + 10'd1;
    end
    pf_on = (nxt_row < V_VIS) && (nxt_col < H_VIS);
    sy    = ADDR_W'(nxt_row >> SCALE_LOG2);
    sx    = ADDR_W'(nxt_col >> SCALE_LOG2);
  end

  // y*FB_W: for the default 160-wide frame this is y*128 + y*32
  if (FB_W == 160) begin : g_shift_add
    assign row_base = (sy << 7) + (sy << 5);
  end else begin : g_mul
    assign row_base = ADDR_W'(sy * ADDR_W'(FB_W));
  end

  assign rd_addr = pf_on ? (row_base + sx) : '0;

  // Display path: prefetch on every col change, swap in at the next change
  always_comb begin
    chg       = (col != col_q);
    px        = chg ? next_q : cur_q;
    col_d     = col;
    cur_d     = px;
    pf_pend_d = chg;
    pf_off_d  = chg ? !pf_on : pf_off_q;
    next_d    = next_q;
    if (pf_pend_q) begin
      next_d = pf_off_q ? 6'd0 : rd_data_q;
    end
  end

  assign color = {2'b00, px};

  // Clear engine: one address per clock while in CLEAR
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    clr_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d     = ST_CLEAR;
          clr_cnt_d   = '0;
          clr_color_d = clr_color;
        end
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt_q == LAST_A) begin
          state_d = ST_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_ready = (state_q == ST_IDLE) && !clr_start;
  assign clr_busy = (state_q == ST_CLEAR);

  // Shared write port; a reset cycle never writes so an aborted fill stops cleanly
  always_comb begin
    mem_we    = !rst && (clr_we || (wr_valid && wr_ready && (wr_addr < DEPTH_A)));
    mem_addr  = clr_we ? clr_cnt_q : wr_addr;
    mem_wdata = clr_we ? clr_color_q : wr_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (chg) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      cur_q       <= '0;
      next_q      <= '0;
      pf_pend_q   <= 1'b0;
      pf_off_q    <= 1'b0;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
`ifdef FB_RESET_CLEAR_EN
      state_q     <= ST_CLEAR;
`else
      state_q     <= ST_IDLE;
`endif
    end else begin
      col_q       <= col_d;
      cur_q       <= cur_d;
      next_q      <= next_d;
      pf_pend_q   <= pf_pend_d;
      pf_off_q    <= pf_off_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_lowres_framebuffer.sv
// Self-checking bench for lowres_framebuffer. The bench positions the raster
// directly (previous pixel, then target pixel, 2 clocks each) and compares the
// displayed color against a frame model indexed by (row/4)*160 + col/4.
module tb_lowres_framebuffer;

  localparam int NPIX = 160 * 120;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  row, col;
  logic [7:0]  color;
  logic        wr_valid, wr_ready;
  logic [14:0] wr_addr;
  logic [5:0]  wr_data;
  logic        clr_start;
  logic [5:0]  clr_color;
  logic        clr_busy;

  int passed = 0;
  int total  = 0;

  int  mdl [NPIX];
  bit  known [NPIX];

  lowres_framebuffer dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .color(color),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected palette index at a raster position; -1 if not yet known
  function automatic int expect_px(input int r, input int c);
    int a;
    if (r >= 480 || c >= 640) return 0;
    a = (r / 4) * 160 + (c / 4);
    return known[a] ? mdl[a] : -1;
  endfunction

  task automatic fill_model(input int from, input int to, input int v);
    for (int i = from; i <= to; i++) begin
      mdl[i] = v;
      known[i] = 1'b1;
    end
  endtask

  // Visit the pixel before (r,c), then (r,c); return color in both clocks of (r,c)
  task automatic show(input int r, input int c, output logic [7:0] c0, output logic [7:0] c1);
    int pr, pc;
    if (c == 0) begin
      pc = 799;
      pr = (r == 0) ? 524 : r - 1;
    end else begin
      pc = c - 1;
      pr = r;
    end
    row = 10'(pr);
    col = (pc == 0) ? 10'd1 : 10'd0;
    tick();
    col = 10'(pc);
    tick();
    tick();
    row = 10'(r);
    col = 10'(c);
    @(negedge clk);
    c0 = color;
    tick();
    @(negedge clk);
    c1 = color;
    tick();
  endtask

  task automatic hw(input int a, input int d, output bit ok);
    ok = 1'b0;
    wr_valid = 1'b1;
    wr_addr = 15'(a);
    wr_data = 6'(d);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    wr_valid = 1'b0;
    if (ok && a < NPIX) begin
      mdl[a] = d;
      known[a] = 1'b1;
    end
  endtask

  // Wait out a running fill; returns the number of busy clocks seen
  task automatic wait_clear(output int n, output int bad_ready);
    n = 0;
    bad_ready = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!clr_busy) break;
      n++;
      if (wr_ready) bad_ready++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n, br;
    rst = 1'b1;
    row = '0; col = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_color = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (color !== 8'h00) $display("FAIL reset_color got=%h exp=00", color); else passed++;
`ifdef FB_RESET_CLEAR_EN
    total++;
    if (clr_busy !== 1'b1 || wr_ready !== 1'b0)
      $display("FAIL reset_busy got busy=%b ready=%b exp busy=1 ready=0", clr_busy, wr_ready);
    else passed++;
    tick();
    wait_clear(n, br);
    total++;
    if (n != NPIX - 1 || br != 0) $display("FAIL reset_clear_len got=%0d bad_ready=%0d exp=%0d", n + 1, br, NPIX);
    else passed++;
    fill_model(0, NPIX - 1, 0);
    tick();
`else
    total++;
    if (clr_busy !== 1'b0 || wr_ready !== 1'b1)
      $display("FAIL reset_idle got busy=%b ready=%b exp busy=0 ready=1", clr_busy, wr_ready);
    else passed++;
    tick();
`endif
  endtask

  task automatic test_first_pixels();
    bit ok;
    logic [7:0] c0, c1;
    int e;
    hw(0, 'h3F, ok);
    hw(1, $urandom_range(0, 63), ok);
    total++;
    if (!ok) $display("FAIL first_write_ack got=0 exp=1"); else passed++;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        show(r, c, c0, c1);
        e = expect_px(r, c);
        total++;
        if (c0 !== 8'(e) || c1 !== 8'(e))
          $display("FAIL first_px r=%0d c=%0d got=%h/%h exp=%h", r, c, c0, c1, 8'(e));
        else passed++;
      end
    end
  endtask

  task automatic test_clear();
    int n, br, e;
    bit ok;
    logic [7:0] c0, c1;
    int rr [6] = '{0, 479, 0, 200, 100, 479};
    int cc [6] = '{20, 639, 700, 650, 100, 0};
    clr_start = 1'b1; clr_color = 6'h15;
    wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 6'h01;
    @(negedge clk);
    total++;
    if (wr_ready !== 1'b0) $display("FAIL clear_vs_write got ready=%b exp=0", wr_ready); else passed++;
    tick();
    clr_start = 1'b0; wr_valid = 1'b0;
    // A second start mid-fill must be ignored
    repeat (1000) tick();
    clr_start = 1'b1; clr_color = 6'h2B;
    tick();
    clr_start = 1'b0;
    wait_clear(n, br);
    total++;
    if (n + 1001 != NPIX || br != 0)
      $display("FAIL clear_len got=%0d bad_ready=%0d exp=%0d", n + 1001, br, NPIX);
    else passed++;
    tick();
    fill_model(0, NPIX - 1, 'h15);
    for (int i = 0; i < 6; i++) begin
      show(rr[i], cc[i], c0, c1);
      e = expect_px(rr[i], cc[i]);
      total++;
      if (c0 !== 8'(e) || c1 !== 8'(e))
        $display("FAIL clear_px r=%0d c=%0d got=%h/%h exp=%h", rr[i], cc[i], c0, c1, 8'(e));
      else passed++;
    end
    hw(5, 'h01, ok);
    show(2, 21, c0, c1);
    total++;
    if (!ok || c0 !== 8'h01 || c1 !== 8'h01)
      $display("FAIL resubmit ack=%b got=%h/%h exp=01", ok, c0, c1);
    else passed++;
  endtask

  task automatic test_oob();
    bit ok;
    logic [7:0] c0, c1;
    hw(NPIX, 'h2A, ok);
    total++;
    if (!ok) $display("FAIL oob_ack got=0 exp=1"); else passed++;
    show(479, 639, c0, c1);
    total++;
    if (c0 !== 8'(expect_px(479, 639))) $display("FAIL oob_nochange got=%h exp=%h", c0, 8'(expect_px(479, 639)));
    else passed++;
    hw(NPIX - 1, 'h2A, ok);
    show(476, 636, c0, c1);
    total++;
    if (c0 !== 8'h2A || c1 !== 8'h2A) $display("FAIL last_px_a got=%h/%h exp=2a", c0, c1); else passed++;
    show(479, 639, c0, c1);
    total++;
    if (c0 !== 8'h2A || c1 !== 8'h2A) $display("FAIL last_px_b got=%h/%h exp=2a", c0, c1); else passed++;
    show(479, 640, c0, c1);
    total++;
    if (c0 !== 8'h00) $display("FAIL past_right got=%h exp=00", c0); else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] c0, c1;
    hw(0, 'h07, ok);
    hw(160, 'h09, ok);
    show(4, 0, c0, c1);
    total++;
    if (c0 !== 8'h09 || c1 !== 8'h09) $display("FAIL wrap_line got=%h/%h exp=09", c0, c1); else passed++;
    show(0, 0, c0, c1);
    total++;
    if (c0 !== 8'h07 || c1 !== 8'h07) $display("FAIL wrap_frame got=%h/%h exp=07", c0, c1); else passed++;
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] c0, c1;
    int a, r, c, e;
    int lr [$];
    int lc [$];
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, NPIX - 1);
      hw(a, $urandom_range(0, 63), ok);
      lr.push_back((a / 160) * 4 + $urandom_range(0, 3));
      lc.push_back((a % 160) * 4 + $urandom_range(0, 3));
    end
    for (int i = 0; i < 40; i++) begin
      if (i < 30) begin
        r = lr[i]; c = lc[i];
      end else begin
        r = $urandom_range(0, 524); c = $urandom_range(0, 799);
      end
      show(r, c, c0, c1);
      e = expect_px(r, c);
      if (e >= 0) begin
        total++;
        if (c0 !== 8'(e) || c1 !== 8'(e))
          $display("FAIL rand_px r=%0d c=%0d got=%h/%h exp=%h", r, c, c0, c1, 8'(e));
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    bit ok;
    logic [7:0] c0, c1;
    int n, br;
    hw(99, 'h11, ok);
    hw(100, 'h22, ok);
    clr_start = 1'b1; clr_color = 6'h33;
    tick();
    clr_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
`ifdef FB_RESET_CLEAR_EN
    total++;
    if (clr_busy !== 1'b1) $display("FAIL abort_busy got=%b exp=1", clr_busy); else passed++;
    tick();
    wait_clear(n, br);
    total++;
    if (n != NPIX - 1) $display("FAIL restart_len got=%0d exp=%0d", n + 1, NPIX); else passed++;
    tick();
    fill_model(0, NPIX - 1, 0);
`else
    total++;
    if (clr_busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", clr_busy); else passed++;
    tick();
    fill_model(0, 99, 'h33);
`endif
    show(2, 396, c0, c1);
    total++;
    if (c0 !== 8'(expect_px(2, 396))) $display("FAIL abort_last got=%h exp=%h", c0, 8'(expect_px(2, 396)));
    else passed++;
    show(0, 400, c0, c1);
    total++;
    if (c0 !== 8'(expect_px(0, 400))) $display("FAIL abort_next got=%h exp=%h", c0, 8'(expect_px(0, 400)));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_first_pixels();
    test_clear();
    test_oob();
    test_wrap();
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
